kbd_event_ctrl: RTL

Scan-code sequencer between the keyboard receiver and game logic. It consumes the byte stream delivered by the PS/2 receiver, walks the set-2 prefix protocol (0xE0 extended, 0xF0 break) and keeps a held-key bitmap for the 16 game keys. Completed key events go into a small show-ahead FIFO read by the game FSM with a valid/ready handshake. It is the single owner of keyboard state: game logic never parses raw scan codes.

---
 rtl/kbd_event_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/kbd_event_ctrl.sv
// PS/2 set-2 scan-code sequencer: prefix parser, held-key bitmap for 16 game keys,
// and a show-ahead event FIFO with valid/ready handshake toward game logic.
module kbd_event_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_code,
    output logic        evt_ext,
    output logic        evt_release,
    output logic [15:0] key_held,
    output logic        overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } evt_t;

    state_t             state;
    state_t             next_state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;

    logic               is_e0;
    logic               is_f0;
    logic               is_e1;
    logic               is_ctrl;
    logic               is_final;
    logic               cur_ext;
    logic               cur_rel;
    logic               map_hit;
    logic [3:0]         map_idx;
    logic               enqueue;

    evt_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               push;
    logic               pop;
    evt_t               new_evt;

    // Byte classification
    always_comb begin
        is_e0    = (byte_data == 8'hE0);
        is_f0    = (byte_data == 8'hF0);
        is_e1    = (byte_data == 8'hE1);
        is_ctrl  = (byte_data == 8'h00) || (byte_data == 8'hAA) || (byte_data == 8'hEE) ||
                   (byte_data == 8'hFA) || (byte_data == 8'hFE) || (byte_data == 8'hFF);
        is_final = byte_valid && !is_e0 && !is_f0 && !is_e1 && !is_ctrl;
        cur_ext  = (state == S_EXT) || (state == S_EXT_BRK);
        cur_rel  = (state == S_BRK) || (state == S_EXT_BRK);
        tmo_hit  = (state != S_IDLE) && !byte_valid &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    // Game key map; extended and plain codes occupy disjoint entries
    always_comb begin
        map_hit = 1'b1;
        map_idx = 4'd0;
        case ({cur_ext, byte_data})
            9'h0_1D: map_idx = 4'd0;
            9'h0_1C: map_idx = 4'd1;
            9'h0_1B: map_idx = 4'd2;
            9'h0_23: map_idx = 4'd3;
            9'h0_29: map_idx = 4'd4;
            9'h0_5A: map_idx = 4'd5;
            9'h0_76: map_idx = 4'd6;
            9'h0_4D: map_idx = 4'd7;
            9'h0_2D: map_idx = 4'd8;
            9'h1_75: map_idx = 4'd9;
            9'h1_72: map_idx = 4'd10;
            9'h1_6B: map_idx = 4'd11;
            9'h1_74: map_idx = 4'd12;
            9'h0_16: map_idx = 4'd13;
            9'h0_1E: map_idx = 4'd14;
            9'h0_26: map_idx = 4'd15;
            default: map_hit = 1'b0;
        endcase
    end

    // Typematic repeats of an already-held key produce no event
    always_comb begin
        enqueue      = is_final && !(map_hit && !cur_rel && key_held[map_idx]);
        new_evt.code = byte_data;
        new_evt.ext  = cur_ext;
        new_evt.rel  = cur_rel;
        full         = (count == CNT_W'(FIFO_DEPTH));
        pop          = (count != '0) && evt_ready;
        push         = enqueue && (!full || pop);
    end

    // Parser next state
    always_comb begin
        next_state = state;
        if (byte_valid) begin
            if (is_e0) begin
                next_state = S_EXT;
            end else if (is_f0) begin
                case (state)
                    S_IDLE:  next_state = S_BRK;
                    S_EXT:   next_state = S_EXT_BRK;
                    default: next_state = state;
                endcase
            end else if (is_e1) begin
                next_state = state;
            end else begin
                next_state = S_IDLE;
            end
        end else if (tmo_hit) begin
            next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= next_state;
            if (byte_valid || (state == S_IDLE) || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    // Held-key bitmap tracks every mapped event, dropped or not
    always_ff @(posedge clk) begin
        if (rst) begin
            key_held <= '0;
            overflow <= 1'b0;
        end else begin
            if (is_final && map_hit) begin
                key_held[map_idx] <= !cur_rel;
            end
            if (enqueue && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_evt;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign evt_valid   = (count != '0);
    assign evt_code    = mem[rd_ptr].code;
    assign evt_ext     = mem[rd_ptr].ext;
    assign evt_release = mem[rd_ptr].rel;

endmodule
